// File: rtl/truth_table_scanner_if.sv
// Stimulus/response bus between the truth-table scanner (master) and the
// circuit pair under check plus whoever reads the scan results (slave).
interface truth_table_scanner_if #(
    parameter int N_IN = 3
);
    logic                 start;
    logic                 f_ref;
    logic                 f_alt;
    logic [N_IN-1:0]      stim;
    logic                 busy;
    logic                 done;
    logic [2**N_IN-1:0]   minterms;
    logic                 equiv;
    logic                 mismatch_valid;
    logic [N_IN-1:0]      first_mismatch;

    modport master (
        input  start, f_ref, f_alt,
        output stim, busy, done, minterms, equiv, mismatch_valid, first_mismatch
    );

    modport slave (
        output start, f_ref, f_alt,
        input  stim, busy, done, minterms, equiv, mismatch_valid, first_mismatch
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Walks every input vector of an N_IN-input circuit pair, records the minterm
// mask of f_ref and reports whether f_alt agrees, with the first failing vector.
module truth_table_scanner #(
    parameter int N_IN       = 3,
    parameter int SETTLE_CYC = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    truth_table_scanner_if.master        bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

    localparam logic [3:0]      RELOAD = 4'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] LAST   = '1;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [N_IN-1:0]      stim_q, stim_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2**N_IN-1:0]   minterms_q, minterms_d;
    logic                 equiv_q, equiv_d;
    logic                 mv_q, mv_d;
    logic [N_IN-1:0]      fm_q, fm_d;

    // NOTE: every _d gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stim_d     = stim_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        minterms_d = minterms_q;
        equiv_d    = equiv_q;
        mv_d       = mv_q;
        fm_d       = fm_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    stim_d     = '0;
                    minterms_d = '0;
                    mv_d       = 1'b0;
                    fm_d       = '0;
                    equiv_d    = 1'b1;
                    cnt_d      = RELOAD;
                    busy_d     = 1'b1;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) state_d = SAMPLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            SAMPLE: begin
                minterms_d[stim_q] = bus.f_ref;
                if (bus.f_ref != bus.f_alt) begin
                    equiv_d = 1'b0;
                    // Only the first disagreement is latched as the reported vector.
                    if (!mv_q) begin
                        fm_d = stim_q;
                        mv_d = 1'b1;
                    end
                end
                if (stim_q == LAST) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    stim_d  = stim_q + 1'b1;
                    cnt_d   = RELOAD;
                    state_d = SETTLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge _d value regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            stim_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            minterms_q <= '0;
            equiv_q    <= 1'b0;
            mv_q       <= 1'b0;
            fm_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stim_q     <= stim_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            minterms_q <= minterms_d;
            equiv_q    <= equiv_d;
            mv_q       <= mv_d;
            fm_q       <= fm_d;
        end
    end

    assign bus.stim           = stim_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.minterms       = minterms_q;
    assign bus.equiv          = equiv_q;
    assign bus.mismatch_valid = mv_q;
    assign bus.first_mismatch = fm_q;
endmodule
